tjmono2_rx_frame_checker: RTL and testbench
===========================================

// Module: tjmono2_rx_frame_checker
// PURPOSE
//  Drains the 32-bit rx FIFO of tjmono2_rx_core, i.e. {ID[3:0], FE_DATA[27:0]}, and checks hit-frame structure.
//  Drops empty records and inserts one timestamp word after each frame header.
//  Drives a valid/ready stream into the readout FIFO arbiter.
//  Counts framing errors for the bus status registers.
// PARAMETERS
//  DATA_IDENTIFIER  0    4-bit ID expected in FIFO_DATA[31:28]; mismatched words are dropped and counted
//  MAX_HITS         255  max hit words per frame; further hits are dropped and counted
//  TS_ID            4'hE  ID placed in [31:28] of inserted timestamp words
// PORTS
//  BUS_CLK        in   1   single clock for all logic
//  BUS_RST        in   1   asynchronous, active-high reset
//  ENABLE         in   1   0: no pops, FSM held in IDLE (counters kept)
//  FIFO_EMPTY     in   1   rx FIFO empty (FWFT: FIFO_DATA is valid whenever low)
//  FIFO_DATA      in   32  rx FIFO head word
//  FIFO_READ      out  1   pop strobe, one word per cycle
//  TIMESTAMP      in   27  free-running timestamp, BUS_CLK domain
//  OUT_DATA       out  32  output word
//  OUT_VALID      out  1   OUT_DATA valid
//  OUT_READY      in   1   downstream accepts when OUT_VALID&OUT_READY
//  CLR_CNT        in   1   synchronous clear of all counters
//  ERR_ORPHAN_CNT out  8   hit/trailer received outside a frame
//  ERR_NOTRL_CNT  out  8   header received inside a frame (missing trailer)
//  ERR_OVF_CNT    out  8   hits dropped because of MAX_HITS
//  ERR_ID_CNT     out  8   words dropped because of ID mismatch
// BEHAVIOUR
//  - Reset values: FIFO_READ=0, OUT_VALID=0, OUT_DATA=0, all counters=0, FSM=IDLE.
//  - Word type is FE_DATA[27:24]: 1=header, 2=hit, 3=trailer, F=empty; other values are treated as hits.
//  - Empty (F) and ID-mismatched words are popped and discarded; no output, no FSM change.
//  - FSM states:
//     IDLE      header -> emit it, go to TS; hit/trailer -> emit, ORPHAN++
//     TS        emit {TS_ID, 1'b0, TS_latched[26:0]} (TS latched at header pop); no pop; go to FRAME
//     FRAME     hit -> emit if hit_cnt<MAX_HITS, else drop and OVF++
//               trailer -> emit, clear hit_cnt, go to IDLE
//               header -> emit, NOTRL++, clear hit_cnt, go to TS (new frame)
//  - Output register is a 2-entry skid buffer.
//     FIFO_READ = !FIFO_EMPTY & ENABLE & (skid has space or word is to be dropped) & state!=TS.
//     Dropped words pop without needing space.
//  - Latency: one cycle from pop to OUT_VALID when the output is free; full throughput of 1 word/cycle.
//  - Backpressure: OUT_VALID & !OUT_READY holds OUT_DATA stable. At most 2 words are buffered; then pops stop.
//  - Counters saturate at 8'hFF.
//     CLR_CNT and an increment in the same cycle -> the counter ends at 0.
//     Two events on one counter in one cycle cannot occur (one word is decoded per cycle).
//  - ENABLE falling mid-frame: stop popping; finish the pending TS insertion; flush the skid; then IDLE.
//     The next header is treated normally and the incomplete frame is not counted.
//  - BUS_RST mid-frame: immediate return to the reset values.
//     Words already in the skid buffer are lost and the rx FIFO is untouched.
//  - hit_cnt is 8-bit (MAX_HITS<=255) and compares unsigned.
// STRUCTURE
//  - tjmono2_rx_pkg: word-type localparams (TYPE_HDR/HIT/TRL/EMPTY) and the TS word-format constants.
//  - One sub-module: tjmono2_skid_buf (2-entry valid/ready buffer, WIDTH parameter).
//    It is reusable by other readout stages.
//  - Top level holds the FSM, the pop/drop decode and the counters.
// TESTING
//  1. Frame header(ts=0x123), 3 hits, trailer with OUT_READY=1
//     -> out: hdr, {E,0,0x0000123}, hit x3, trl; all counters 0.
//  2. 10 empty words interleaved in frame 1 -> same 6-word output; 10 extra pops.
//  3. Hit before any header -> hit passed, ERR_ORPHAN_CNT=1.
//     Header,header,trailer -> NOTRL=1, and each header is followed by its own TS word.
//  4. MAX_HITS=4, frame with 6 hits -> 4 hits out, ERR_OVF_CNT=2, trailer still emitted.
//  5. OUT_READY toggled randomly (50%) over 1000 random frames
//     -> output equals the reference-model sequence, no loss/duplication, OUT_DATA stable while stalled.
//  6. Wrong ID words x300 -> ERR_ID_CNT saturates at 255; CLR_CNT -> 0.
//     BUS_RST mid-frame -> outputs at their reset values and FSM in IDLE.

Source files
------------

// File: rtl/tjmono2_rx_pkg.sv
// Shared word-format constants and helpers for the tjmono2 rx readout path.
// Word layout: {ID[3:0], TYPE[3:0], PAYLOAD[23:0]}.
package tjmono2_rx_pkg;

  localparam logic [3:0] TYPE_HDR   = 4'h1;
  localparam logic [3:0] TYPE_HIT   = 4'h2;
  localparam logic [3:0] TYPE_TRL   = 4'h3;
  localparam logic [3:0] TYPE_EMPTY = 4'hF;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TS_W   = 27;
  localparam logic        TS_PAD = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StTs,
    StFrame
  } state_e;

  // Saturating 8-bit counter step; a clear in the same cycle wins.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc,
                                         input logic clr);
    logic [7:0] res;
    res = cnt;
    if (clr) begin
      res = 8'h00;
    end else if (inc && (cnt != 8'hFF)) begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tjmono2_skid_buf.sv
// Two-entry valid/ready buffer with a registered output and registered ready.
// Accepts a word whenever fewer than two are held, so it sustains one word per cycle.
module tjmono2_skid_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = in_data_i;
        end else begin
          tail_d = in_data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_data_i;
        end else begin
          head_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tjmono2_rx_frame_checker.sv
// Drains the rx FIFO, checks hit-frame structure, inserts a timestamp word after each
// header and streams the result out through a two-entry skid buffer.
module tjmono2_rx_frame_checker
  import tjmono2_rx_pkg::*;
#(
  parameter logic [3:0]  DATA_IDENTIFIER = 4'h0,
  parameter int unsigned MAX_HITS        = 255,
  parameter logic [3:0]  TS_ID           = 4'hE
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  input  logic              ENABLE,
  input  logic              FIFO_EMPTY,
  input  logic [31:0]       FIFO_DATA,
  output logic              FIFO_READ,
  input  logic [TS_W-1:0]   TIMESTAMP,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  input  logic              CLR_CNT,
  output logic [7:0]        ERR_ORPHAN_CNT,
  output logic [7:0]        ERR_NOTRL_CNT,
  output logic [7:0]        ERR_OVF_CNT,
  output logic [7:0]        ERR_ID_CNT
);

  localparam logic [7:0] MaxHits = 8'(MAX_HITS);

  state_e            state_q, state_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [7:0]        orphan_q, orphan_d, notrl_q, notrl_d, ovf_q, ovf_d, id_q, id_d;

  logic              skid_ready, skid_push;
  logic [WORD_W-1:0] skid_data;
  logic              id_ok, is_hdr, is_trl, is_empty, is_hit;
  logic              ovf_drop, drop, avail, pop, accept;
  logic              orphan_inc, notrl_inc;

  assign id_ok    = (FIFO_DATA[31:28] == DATA_IDENTIFIER);
  assign is_hdr   = (FIFO_DATA[27:24] == TYPE_HDR);
  assign is_trl   = (FIFO_DATA[27:24] == TYPE_TRL);
  assign is_empty = (FIFO_DATA[27:24] == TYPE_EMPTY);
  // Any type code that is not header/trailer/empty counts as a hit.
  assign is_hit   = !is_hdr && !is_trl && !is_empty;
  assign ovf_drop = id_ok && is_hit && (state_q == StFrame) && (hit_cnt_q >= MaxHits);
  assign drop     = !id_ok || is_empty || ovf_drop;
  assign avail    = !FIFO_EMPTY && ENABLE && (state_q != StTs);
  // Dropped words never enter the skid, so they may pop even when it is full.
  assign pop      = avail && (skid_ready || drop);
  assign accept   = pop && !drop;

  assign FIFO_READ = pop && !BUS_RST;

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    ts_d       = ts_q;
    skid_push  = 1'b0;
    skid_data  = FIFO_DATA;
    orphan_inc = 1'b0;
    notrl_inc  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          skid_push = 1'b1;
          if (is_hdr) begin
            ts_d    = TIMESTAMP;
            state_d = StTs;
          end else begin
            orphan_inc = 1'b1;
          end
        end
      end
      StTs: begin
        if (skid_ready) begin
          skid_push = 1'b1;
          skid_data = {TS_ID, TS_PAD, ts_q};
          state_d   = ENABLE ? StFrame : StIdle;
        end
      end
      StFrame: begin
        if (accept) begin
          skid_push = 1'b1;
          if (is_hdr) begin
            notrl_inc = 1'b1;
            hit_cnt_d = 8'd0;
            ts_d      = TIMESTAMP;
            state_d   = StTs;
          end else if (is_trl) begin
            hit_cnt_d = 8'd0;
            state_d   = StIdle;
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pending timestamp is always completed before the enable-off return to idle.
    if (!ENABLE && (state_q != StTs)) begin
      state_d   = StIdle;
      hit_cnt_d = 8'd0;
    end
  end

  always_comb begin
    orphan_d = sat_inc(orphan_q, orphan_inc, CLR_CNT);
    notrl_d  = sat_inc(notrl_q, notrl_inc, CLR_CNT);
    ovf_d    = sat_inc(ovf_q, pop && ovf_drop, CLR_CNT);
    id_d     = sat_inc(id_q, pop && !id_ok, CLR_CNT);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q   <= StIdle;
      hit_cnt_q <= 8'd0;
      ts_q      <= '0;
      orphan_q  <= 8'd0;
      notrl_q   <= 8'd0;
      ovf_q     <= 8'd0;
      id_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      hit_cnt_q <= hit_cnt_d;
      ts_q      <= ts_d;
      orphan_q  <= orphan_d;
      notrl_q   <= notrl_d;
      ovf_q     <= ovf_d;
      id_q      <= id_d;
    end
  end

  assign ERR_ORPHAN_CNT = orphan_q;
  assign ERR_NOTRL_CNT  = notrl_q;
  assign ERR_OVF_CNT    = ovf_q;
  assign ERR_ID_CNT     = id_q;

  tjmono2_skid_buf #(
    .WIDTH(WORD_W)
  ) u_skid (
    .clk_i      (BUS_CLK),
    .rst_i      (BUS_RST),
    .in_valid_i (skid_push),
    .in_ready_o (skid_ready),
    .in_data_i  (skid_data),
    .out_valid_o(OUT_VALID),
    .out_ready_i(OUT_READY),
    .out_data_o (OUT_DATA)
  );

endmodule

// File: tb/tb_tjmono2_rx_frame_checker.sv
// Scoreboard bench for tjmono2_rx_frame_checker: a FWFT FIFO model feeds the DUT,
// stimulus queues expected words, and a monitor checks every accepted output word.
module tb_tjmono2_rx_frame_checker;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST, ENABLE, FIFO_EMPTY, FIFO_READ, OUT_VALID, OUT_READY, CLR_CNT;
  logic [31:0] FIFO_DATA, OUT_DATA;
  logic [26:0] TIMESTAMP;
  logic [7:0]  ERR_ORPHAN_CNT, ERR_NOTRL_CNT, ERR_OVF_CNT, ERR_ID_CNT;

  typedef struct {
    logic        is_ts;
    logic [31:0] w;
  } exp_t;

  logic [31:0] fifo_q[$];
  logic [26:0] tsq[$];
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          pops = 0;
  logic        ts_run = 1'b0;
  logic        rnd_rdy = 1'b0;

  tjmono2_rx_frame_checker #(
    .DATA_IDENTIFIER(4'h0),
    .MAX_HITS       (4),
    .TS_ID          (4'hE)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST       (BUS_RST),
    .ENABLE        (ENABLE),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_DATA     (FIFO_DATA),
    .FIFO_READ     (FIFO_READ),
    .TIMESTAMP     (TIMESTAMP),
    .OUT_DATA      (OUT_DATA),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .CLR_CNT       (CLR_CNT),
    .ERR_ORPHAN_CNT(ERR_ORPHAN_CNT),
    .ERR_NOTRL_CNT (ERR_NOTRL_CNT),
    .ERR_OVF_CNT   (ERR_OVF_CNT),
    .ERR_ID_CNT    (ERR_ID_CNT)
  );

  initial forever #5 BUS_CLK = ~BUS_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, want);
    end
  endtask

  task automatic upd();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_DATA  = FIFO_EMPTY ? 32'h0 : fifo_q[0];
  endtask

  task automatic send(input logic [31:0] w);
    fifo_q.push_back(w);
    upd();
  endtask

  task automatic ex(input logic [31:0] w);
    exp_q.push_back('{is_ts: 1'b0, w: w});
  endtask

  task automatic ex_ts();
    exp_q.push_back('{is_ts: 1'b1, w: 32'h0});
  endtask

  task automatic chk_cnt(input string name, input logic [7:0] o, input logic [7:0] n,
                         input logic [7:0] v, input logic [7:0] i);
    chk({name, "_orphan"}, {24'h0, ERR_ORPHAN_CNT}, {24'h0, o});
    chk({name, "_notrl"}, {24'h0, ERR_NOTRL_CNT}, {24'h0, n});
    chk({name, "_ovf"}, {24'h0, ERR_OVF_CNT}, {24'h0, v});
    chk({name, "_id"}, {24'h0, ERR_ID_CNT}, {24'h0, i});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || OUT_VALID) && n < 60000) begin
      @(negedge BUS_CLK);
      n++;
    end
    n_chk++;
    if (n >= 60000) begin
      n_fail++;
      $display("FAIL %s_drain: actual %0d words left required 0", name, exp_q.size());
    end
    repeat (3) @(posedge BUS_CLK);
    #1;
    tsq.delete();
  endtask

  task automatic clr();
    CLR_CNT = 1'b1;
    @(posedge BUS_CLK);
    #1;
    CLR_CNT = 1'b0;
  endtask

  // FWFT rx FIFO model; records the timestamp seen at each good header pop.
  initial begin
    logic        rd;
    logic [26:0] ts_s;
    logic [31:0] w;
    forever begin
      @(negedge BUS_CLK);
      rd   = FIFO_READ;
      ts_s = TIMESTAMP;
      @(posedge BUS_CLK);
      #1;
      if (rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        pops++;
        if (w[31:28] == 4'h0 && w[27:24] == 4'h1) tsq.push_back(ts_s);
      end
      upd();
    end
  end

  initial forever begin
    @(posedge BUS_CLK);
    #1;
    if (ts_run) TIMESTAMP = TIMESTAMP + 27'd1;
    if (rnd_rdy) OUT_READY = ($urandom_range(0, 1) == 1);
  end

  // Monitor: compares accepted words and checks hold-stability while stalled.
  initial begin
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'h0;
    logic [31:0] want;
    exp_t        e;
    forever begin
      @(negedge BUS_CLK);
      if (BUS_RST) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", {31'h0, OUT_VALID}, 32'h1);
          chk("stall_data", OUT_DATA, stall_data);
        end
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_extra: actual %h required no word", OUT_DATA);
          end else begin
            e    = exp_q.pop_front();
            want = e.w;
            if (e.is_ts) want = {4'hE, 1'b0, (tsq.size() > 0) ? tsq.pop_front() : 27'h7FFFFFF};
            chk("out_word", OUT_DATA, want);
          end
        end
        stall_prev = OUT_VALID && !OUT_READY;
        stall_data = OUT_DATA;
      end
    end
  end

  initial begin
    int          p0, ovf_tot, id_tot, nh;
    logic [31:0] w;
    BUS_RST = 1'b1; ENABLE = 1'b1; OUT_READY = 1'b1; CLR_CNT = 1'b0;
    TIMESTAMP = 27'h123;
    upd();
    send(32'h01000001);
    repeat (2) @(negedge BUS_CLK);
    chk("rst_fifo_read", {31'h0, FIFO_READ}, 32'h0);
    chk("rst_out_valid", {31'h0, OUT_VALID}, 32'h0);
    chk("rst_out_data", OUT_DATA, 32'h0);
    chk_cnt("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge BUS_CLK);
    #1;
    fifo_q.delete();
    upd();
    BUS_RST = 1'b0;
    @(posedge BUS_CLK);
    #1;

    // 1: basic frame, fixed timestamp
    send(32'h01A00001); ex(32'h01A00001); ex(32'hE0000123);
    for (int i = 1; i <= 3; i++) begin
      w = {8'h02, 20'h0, 4'(i)}; send(w); ex(w);
    end
    send(32'h03000003); ex(32'h03000003);
    drain("t1");
    chk_cnt("t1", 8'd0, 8'd0, 8'd0, 8'd0);

    // 2: same frame with 10 empty words interleaved
    p0 = pops;
    send(32'h01A00001); ex(32'h01A00001); ex(32'hE0000123);
    send(32'h0F000000); send(32'h0F111111);
    for (int i = 1; i <= 3; i++) begin
      w = {8'h02, 20'h0, 4'(i)}; send(w); ex(w);
      send(32'h0FABCDEF); send(32'h0F000001);
    end
    send(32'h03000003); ex(32'h03000003);
    send(32'h0F222222); send(32'h0F333333);
    drain("t2");
    chk("t2_pops", 32'(pops - p0), 32'd15);
    chk_cnt("t2", 8'd0, 8'd0, 8'd0, 8'd0);
    ts_run = 1'b1;

    // 3: orphan hit (type 7 decodes as hit), then header, header, trailer
    send(32'h07000077); ex(32'h07000077);
    send(32'h01000A0A); ex(32'h01000A0A); ex_ts();
    send(32'h01000B0B); ex(32'h01000B0B); ex_ts();
    send(32'h03000C0C); ex(32'h03000C0C);
    drain("t3");
    chk_cnt("t3", 8'd1, 8'd1, 8'd0, 8'd0);
    clr();
    chk_cnt("t3_clr", 8'd0, 8'd0, 8'd0, 8'd0);

    // 4: MAX_HITS=4, six hits
    send(32'h01000040); ex(32'h01000040); ex_ts();
    for (int i = 1; i <= 6; i++) begin
      w = {8'h02, 20'h00400, 4'(i)}; send(w);
      if (i <= 4) ex(w);
    end
    send(32'h03000040); ex(32'h03000040);
    drain("t4");
    chk_cnt("t4", 8'd0, 8'd0, 8'd2, 8'd0);
    clr();

    // 5: 1000 random frames under random backpressure
    ovf_tot = 0; id_tot = 0;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      nh = $urandom_range(0, 6);
      w = {8'h01, 24'($urandom)}; send(w); ex(w); ex_ts();
      if ($urandom_range(0, 3) == 0) send({8'h0F, 24'($urandom)});
      if ($urandom_range(0, 4) == 0) begin
        send({4'h5, 28'($urandom)}); id_tot++;
      end
      for (int h = 0; h < nh; h++) begin
        w = {4'h0, ($urandom_range(0, 3) == 0) ? 4'h9 : 4'h2, 24'($urandom)};
        send(w);
        if (h < 4) ex(w); else ovf_tot++;
      end
      w = {8'h03, 24'($urandom)}; send(w); ex(w);
    end
    drain("t5");
    rnd_rdy = 1'b0;
    OUT_READY = 1'b1;
    chk_cnt("t5", 8'd0, 8'd0, (ovf_tot > 255) ? 8'hFF : 8'(ovf_tot),
            (id_tot > 255) ? 8'hFF : 8'(id_tot));
    clr();

    // 6: ID counter saturation and clear
    for (int i = 0; i < 300; i++) send({4'h3, 4'(i), 24'(i)});
    drain("t6");
    chk_cnt("t6_sat", 8'd0, 8'd0, 8'd0, 8'hFF);
    clr();
    chk_cnt("t6_clr", 8'd0, 8'd0, 8'd0, 8'd0);

    // 6b: reset mid-frame with a full skid buffer
    OUT_READY = 1'b0;
    send(32'h02000099); send(32'h01000042); send(32'h020000AA);
    repeat (6) @(posedge BUS_CLK);
    #1;
    chk("t6_pre_orphan", {24'h0, ERR_ORPHAN_CNT}, 32'h1);
    chk("t6_pre_valid", {31'h0, OUT_VALID}, 32'h1);
    BUS_RST = 1'b1;
    fifo_q.delete(); exp_q.delete(); tsq.delete();
    send(32'h020000AA);
    @(negedge BUS_CLK);
    chk("t6_rst_valid", {31'h0, OUT_VALID}, 32'h0);
    chk("t6_rst_data", OUT_DATA, 32'h0);
    chk("t6_rst_read", {31'h0, FIFO_READ}, 32'h0);
    chk_cnt("t6_rst", 8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge BUS_CLK);
    #1;
    fifo_q.delete();
    upd();
    BUS_RST = 1'b0;
    OUT_READY = 1'b1;
    send(32'h020000BB); ex(32'h020000BB);
    drain("t6_post");
    chk_cnt("t6_post", 8'd1, 8'd0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
